// File: rtl/mole_round_ctrl.sv
// rtl/mole_round_ctrl.sv - whack-a-mole round sequencer: timed rounds, mole retirement, saturating score
// Optional feature macro: CLEAR_BONUS_EN (adds +2 when all moles are cleared before timeout).
module mole_round_ctrl #(
    parameter int N_MOLES    = 18,
    parameter int ROUNDS     = 30,
    parameter int SHOW_TICKS = 20,
    parameter int GAP_TICKS  = 5,
    parameter int SCORE_W    = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               tick,
    input  logic [N_MOLES-1:0] rand_in,
    input  logic [N_MOLES-1:0] hit_reg,
    output logic [N_MOLES-1:0] moles,
    output logic [SCORE_W-1:0] score,
    output logic [7:0]         round,
    output logic [7:0]         time_left,
    output logic               busy,
    output logic               game_over
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_SHOW = 3'd2;
    localparam logic [2:0] S_GAP  = 3'd3;
    localparam logic [2:0] S_OVER = 3'd4;

    localparam int CNT_W = $clog2(N_MOLES + 1);
    localparam int SUM_W = SCORE_W + CNT_W + 2;
`ifdef CLEAR_BONUS_EN
    localparam int BONUS = 2;
`else
    localparam int BONUS = 0;
`endif

    logic [2:0]         state;
    logic [N_MOLES-1:0] fallback;
    logic [N_MOLES-1:0] hits;
    logic [N_MOLES-1:0] remaining;
    logic [CNT_W-1:0]   hit_cnt;
    logic [SUM_W-1:0]   sum;
    logic [SCORE_W-1:0] score_next;
    logic               cleared;
    logic               timeout;

    // Only bits that are currently up can score; a retired mole is already 0 in moles.
    always_comb begin
        hits      = hit_reg & moles;
        remaining = moles & ~hits;
        cleared   = (remaining == '0);
        timeout   = tick && (time_left == 8'd1);
        hit_cnt   = '0;
        for (int i = 0; i < N_MOLES; i++) begin
            hit_cnt = hit_cnt + CNT_W'(hits[i]);
        end
        sum = SUM_W'(score) + SUM_W'(hit_cnt) + (cleared ? SUM_W'(BONUS) : '0);
        if (|sum[SUM_W-1:SCORE_W]) begin
            score_next = '1;
        end else begin
            score_next = sum[SCORE_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            fallback  <= N_MOLES'(1);
            moles     <= '0;
            score     <= '0;
            round     <= '0;
            time_left <= '0;
            busy      <= 1'b0;
            game_over <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_OVER: begin
                    moles <= '0;
                    if (start) begin
                        score     <= '0;
                        round     <= '0;
                        busy      <= 1'b1;
                        game_over <= 1'b0;
                        state     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // An all-zero pattern would end the round instantly, so fall back to a walking bit.
                    moles     <= (rand_in != '0) ? rand_in : fallback;
                    fallback  <= {fallback[N_MOLES-2:0], fallback[N_MOLES-1]};
                    time_left <= 8'(SHOW_TICKS);
                    round     <= round + 8'd1;
                    state     <= S_SHOW;
                end
                S_SHOW: begin
                    score <= score_next;
                    if (cleared || timeout) begin
                        moles     <= '0;
                        time_left <= 8'(GAP_TICKS);
                        state     <= S_GAP;
                    end else begin
                        moles <= remaining;
                        if (tick) begin
                            time_left <= time_left - 8'd1;
                        end
                    end
                end
                S_GAP: begin
                    moles <= '0;
                    if (time_left == 8'd0) begin
                        if (round == 8'(ROUNDS)) begin
                            busy      <= 1'b0;
                            game_over <= 1'b1;
                            state     <= S_OVER;
                        end else begin
                            state <= S_LOAD;
                        end
                    end else if (tick) begin
                        time_left <= time_left - 8'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    moles <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mole_round_ctrl.sv
// tb/tb_mole_round_ctrl.sv - self-checking bench for mole_round_ctrl against a behavioural game model
module tb_mole_round_ctrl;

    localparam int N    = 18;
    localparam int SHOW = 4;
    localparam int GAP  = 2;
    localparam int RNDS = 3;
    localparam int SW   = 10;
    localparam int SW2  = 2;
`ifdef CLEAR_BONUS_EN
    localparam int BONUS = 2;
`else
    localparam int BONUS = 0;
`endif

    logic         clk = 1'b0;
    logic         rst, start, tick;
    logic [N-1:0] rand_in, hit_reg;
    logic [N-1:0] moles, moles2;
    logic [SW-1:0]  score;
    logic [SW2-1:0] score2;
    logic [7:0]   round, time_left, round2, time_left2;
    logic         busy, game_over, busy2, game_over2;

    always #5 clk = ~clk;

    mole_round_ctrl #(.N_MOLES(N), .ROUNDS(RNDS), .SHOW_TICKS(SHOW), .GAP_TICKS(GAP), .SCORE_W(SW)) dut (
        .clk(clk), .rst(rst), .start(start), .tick(tick), .rand_in(rand_in), .hit_reg(hit_reg),
        .moles(moles), .score(score), .round(round), .time_left(time_left), .busy(busy), .game_over(game_over)
    );

    mole_round_ctrl #(.N_MOLES(N), .ROUNDS(RNDS), .SHOW_TICKS(SHOW), .GAP_TICKS(GAP), .SCORE_W(SW2)) dut_sat (
        .clk(clk), .rst(rst), .start(start), .tick(tick), .rand_in(rand_in), .hit_reg(hit_reg),
        .moles(moles2), .score(score2), .round(round2), .time_left(time_left2), .busy(busy2), .game_over(game_over2)
    );

    typedef enum int {P_IDLE, P_LOAD, P_SHOW, P_GAP, P_OVER} phase_t;
    phase_t       m_ph;
    logic [N-1:0] m_moles;
    int           m_score, m_round, m_time, m_fb;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        bit           r, s, t;
        logic [N-1:0] rnd, hit;
        int           e_moles, e_score, e_round;
        bit           e_busy, e_go;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_step();
        logic [N-1:0] h, rem;
        if (rst) begin
            m_ph = P_IDLE; m_moles = '0; m_score = 0; m_round = 0; m_time = 0; m_fb = 0;
            return;
        end
        case (m_ph)
            P_IDLE, P_OVER: begin
                if (start) begin
                    m_score = 0; m_round = 0; m_ph = P_LOAD;
                end
            end
            P_LOAD: begin
                m_moles = (rand_in != '0) ? rand_in : N'(1 << m_fb);
                m_fb    = (m_fb + 1) % N;
                m_time  = SHOW;
                m_round = m_round + 1;
                m_ph    = P_SHOW;
            end
            P_SHOW: begin
                h   = hit_reg & m_moles;
                rem = m_moles & ~h;
                m_score = sat(m_score + $countones(h) + ((rem == '0) ? BONUS : 0), SW);
                if (rem == '0 || (tick && m_time == 1)) begin
                    m_moles = '0; m_time = GAP; m_ph = P_GAP;
                end else begin
                    m_moles = rem;
                    if (tick) m_time = m_time - 1;
                end
            end
            P_GAP: begin
                if (m_time == 0) m_ph = (m_round == RNDS) ? P_OVER : P_LOAD;
                else if (tick) m_time = m_time - 1;
            end
            default: m_ph = P_IDLE;
        endcase
    endtask

    task automatic compare_all();
        bit exp_busy;
        exp_busy = (m_ph == P_LOAD || m_ph == P_SHOW || m_ph == P_GAP);
        chk("moles", int'(moles), int'(m_moles));
        chk("score", int'(score), m_score);
        chk("round", int'(round), m_round);
        chk("time_left", int'(time_left), m_time);
        chk("busy", int'(busy), int'(exp_busy));
        chk("game_over", int'(game_over), int'(m_ph == P_OVER));
        chk("sat_score", int'(score2), sat(m_score, SW2));
        chk("sat_moles", int'(moles2), int'(m_moles));
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic drive(input bit r, input bit s, input bit t, input logic [N-1:0] rn, input logic [N-1:0] h);
        rst = r; start = s; tick = t; rand_in = rn; hit_reg = h;
    endtask

    initial begin
        phase_t prev;
        int k;
        drive(1, 0, 0, '0, '0);
        m_ph = P_IDLE; m_moles = '0; m_score = 0; m_round = 0; m_time = 0; m_fb = 0;
        @(negedge clk);

        // Directed table: reset, start, single hit, repeated hit, clear-out.
        tbl[0] = '{1, 0, 0, 18'h00000, 18'h00000, 0, 0,         0, 0, 0};
        tbl[1] = '{1, 0, 0, 18'h00000, 18'h00000, 0, 0,         0, 0, 0};
        tbl[2] = '{0, 1, 0, 18'h00005, 18'h00000, 0, 0,         0, 1, 0};
        tbl[3] = '{0, 0, 0, 18'h00005, 18'h00000, 5, 0,         1, 1, 0};
        tbl[4] = '{0, 0, 0, 18'h00005, 18'h00001, 4, 1,         1, 1, 0};
        tbl[5] = '{0, 0, 0, 18'h00005, 18'h00001, 4, 1,         1, 1, 0};
        tbl[6] = '{0, 0, 0, 18'h00005, 18'h00004, 0, 2 + BONUS, 1, 1, 0};
        for (int i = 0; i < 7; i++) begin
            drive(tbl[i].r, tbl[i].s, tbl[i].t, tbl[i].rnd, tbl[i].hit);
            step();
            chk($sformatf("tbl%0d_moles", i), int'(moles), tbl[i].e_moles);
            chk($sformatf("tbl%0d_score", i), int'(score), tbl[i].e_score);
            chk($sformatf("tbl%0d_round", i), int'(round), tbl[i].e_round);
            chk($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].e_busy));
            chk($sformatf("tbl%0d_go", i), int'(game_over), int'(tbl[i].e_go));
        end

        // Full game with no hits, tick every 4 cycles.
        drive(1, 0, 0, '0, '0); step();
        drive(0, 1, 0, 18'h2a5a5, '0); step();
        start = 0;
        for (int c = 0; c < 400 && m_ph != P_OVER; c++) begin
            tick = (c % 4 == 3);
            step();
        end
        chk("game_over_reached", int'(game_over), 1);
        chk("game_rounds", int'(round), RNDS);
        chk("game_score", int'(score), 0);

        // Fallback walking bit across three LOADs with rand_in=0.
        drive(1, 0, 0, '0, '0); step();
        drive(0, 1, 1, '0, '0); step();
        start = 0;
        k = 0;
        for (int c = 0; c < 80 && m_ph != P_OVER; c++) begin
            prev = m_ph;
            step();
            if (prev == P_LOAD) begin
                chk($sformatf("fallback%0d", k), int'(moles), 1 << k);
                k++;
            end
        end
        chk("fallback_count", k, 3);

        // Saturation on the 2-bit score instance.
        drive(1, 0, 0, '0, '0); step();
        drive(0, 1, 0, 18'h0000f, '0); step();
        drive(0, 0, 0, 18'h0000f, '0); step();
        for (int i = 0; i < 4; i++) begin
            hit_reg = N'(1 << i);
            step();
        end
        chk("sat_at_3", int'(score2), 3);
        chk("wide_score", int'(score), 4 + BONUS);

        // Hit coinciding with timeout, and start ignored while busy.
        drive(1, 0, 0, '0, '0); step();
        drive(0, 1, 0, 18'h00003, '0); step();
        drive(0, 0, 0, 18'h00003, '0); step();
        drive(0, 1, 0, 18'h00003, '0); step();
        chk("start_ignored_round", int'(round), 1);
        chk("start_ignored_busy", int'(busy), 1);
        drive(0, 0, 1, 18'h00003, '0);
        for (int i = 0; i < 3; i++) step();
        chk("time_at_one", int'(time_left), 1);
        hit_reg = 18'h00001; step();
        chk("timeout_hit_score", int'(score), 1);
        chk("timeout_moles", int'(moles), 0);
        chk("timeout_gap_time", int'(time_left), GAP);

        // Reset in the GAP of round 2.
        hit_reg = '0;
        for (int c = 0; c < 60 && !(m_ph == P_GAP && m_round == 2); c++) step();
        chk("reached_gap2", int'(round), 2);
        rst = 1; step(); rst = 0;
        chk("midreset_round", int'(round), 0);
        chk("midreset_score", int'(score), 0);
        chk("midreset_busy", int'(busy), 0);

        // Randomized play against the model.
        for (int c = 0; c < 3000; c++) begin
            rst     = ($urandom_range(0, 199) == 0);
            start   = ($urandom_range(0, 7) == 0);
            tick    = ($urandom_range(0, 2) == 0);
            rand_in = ($urandom_range(0, 4) == 0) ? '0 : N'($urandom & $urandom & $urandom);
            hit_reg = N'($urandom & $urandom);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mole_round_ctrl.md
Name: mole_round_ctrl

Overview:
Game sequencer for the whack-a-mole datapath. It runs a fixed number of timed rounds. Each round it latches a mole pattern from the random source and drives it to the whack stage. It retires moles as hits come back, accumulates a saturating score, and ends the game after the last round. All outputs are registered; the block sits between the LFSR, the whack stage and the score/7-seg display logic.

Parameters:
N_MOLES, 18, number of mole positions (switch/LED width)
ROUNDS, 30, rounds per game (1..255)
SHOW_TICKS, 20, tick periods a mole pattern stays up (1..255)
GAP_TICKS, 5, tick periods of dark gap between rounds (0..255)
SCORE_W, 10, score counter width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse, begins a game; ignored while busy
tick  in  1  one-cycle timebase enable (e.g. 1 s strobe)
rand_in  in  N_MOLES  pattern from random number generator
hit_reg  in  N_MOLES  successful-hit bits from whack stage (same cycle as moles)
moles  out  N_MOLES  active mole pattern to whack stage
score  out  SCORE_W  accumulated hits, saturating
round  out  8  current round number, 1-based; 0 before first round
time_left  out  8  ticks remaining in current SHOW or GAP phase
busy  out  1  high in LOAD/SHOW/GAP
game_over  out  1  high in OVER

Behaviour:
- Reset (synchronous, active-high; one clock, one synchronous reset, nothing asynchronous): state=IDLE; moles=0, score=0, round=0, time_left=0, busy=0, game_over=0. Reset mid-game aborts immediately, with no partial scoring that cycle.
- States: IDLE, LOAD, SHOW, GAP, OVER.
- IDLE: on start, clear score and round, go to LOAD next cycle.
- LOAD (exactly 1 cycle):
  - moles <= rand_in if nonzero, else fallback one-hot (rotating register, reset to bit 0, rotates left once per LOAD).
  - time_left <= SHOW_TICKS; round <= round+1; go to SHOW.
- SHOW, each cycle:
  - h = hit_reg & moles.
  - score <= min(score + popcount(h), 2^SCORE_W-1).
  - moles <= moles & ~h. A retired mole can never score twice in a round.
  - On tick: time_left decrements.
- SHOW exit: when (moles & ~h)==0, or tick with time_left==1. Next cycle: moles=0, time_left=GAP_TICKS, state GAP.
- SHOW simultaneous events: a hit and the timeout tick in the same cycle still score. Bits of hit_reg outside moles are ignored.
- GAP: moles held 0. On tick, time_left decrements. When time_left==0: go to OVER if round==ROUNDS, else go to LOAD. GAP_TICKS=0 means a single GAP cycle.
- OVER: game_over=1, busy=0, moles=0; score and round held. start clears score/round and goes to LOAD (game_over drops the same edge).
- tick while in IDLE or OVER has no effect. start while busy is ignored.
- Latency: start to moles valid = 2 cycles; hit to score/moles update = 1 cycle.

Optional Feature:
CLEAR_BONUS_EN:
- Defined: when SHOW exits because all moles were cleared before timeout, add +2 to score (saturating), on top of the hit count in the exit cycle.
- Undefined: no bonus; the score equals total hits exactly.

Test Plan:
1. Bench params SHOW_TICKS=4, GAP_TICKS=2, ROUNDS=3. Assert rst for 2 cycles → all outputs 0, state IDLE. Then pulse start, tick every 4 cycles, no hits → round 1,2,3 each with moles=rand_in for 4 ticks. Then game_over=1, score=0.
2. rand_in=18'h00005, hit_reg=18'h00001 for one cycle in SHOW → next cycle moles=18'h00004, score=1. Repeat same hit_reg → score stays 1.
3. rand_in=18'h00003, hit_reg=18'h00003 in one cycle → score=2, moles=0, state GAP before timeout. With CLEAR_BONUS_EN, score=4.
4. rand_in=0 at three consecutive LOADs → moles=18'h00001, 18'h00002, 18'h00004.
5. Hit on a mole in the same cycle as tick with time_left==1 → hit scored, GAP entered. Pulse start during SHOW → ignored, round unchanged.
6. SCORE_W=2, four single hits → score saturates at 3. Assert rst during GAP of round 2 → IDLE, score=0, round=0 next cycle.
